// File: rtl/fft_peak_detect_if.sv
// Bundle carrying FFT output beats into the peak detector and its per-frame result.
// DATA_W is the sample width and IDX_W the bin-index width. Both must match the detector instance.
interface fft_peak_detect_if #(
  parameter int DATA_W = 14,
  parameter int IDX_W  = 10
);
  // Handshake: a beat transfers on a rising clock edge where source_valid and source_ready are both 1.
  // The beat fields must be stable while source_valid is high. peak_valid is a one-cycle pulse that
  // carries no back-pressure.
  logic                       source_valid;
  logic                       source_sop;
  logic                       source_eop;
  logic [1:0]                 source_error;
  logic signed [DATA_W-1:0]   source_real;
  logic signed [DATA_W-1:0]   source_imag;
  logic                       source_ready;
  logic                       peak_valid;
  logic [IDX_W-1:0]           peak_bin;
  logic [2*DATA_W-1:0]        peak_power;
  logic                       frame_err;

  modport master (
    output source_valid, source_sop, source_eop, source_error, source_real, source_imag,
    input  source_ready, peak_valid, peak_bin, peak_power, frame_err
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_error, source_real, source_imag,
    output source_ready, peak_valid, peak_bin, peak_power, frame_err
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over FFT bins: 3-stage power/compare pipeline plus a frame FSM.
// Optional macro PEAK_SKIP_DC_EN excludes bin 0 from the search.
module fft_peak_detect #(
  parameter  int DATA_W  = 14,
  parameter  int FFT_LEN = 1024,
  localparam int IDX_W   = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_peak_detect_if.slave    src,
  output logic [1:0]          dbg_state_o
);
  localparam int PW = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, REPORT} state_e;
  state_e state_q, state_d;

  logic             acc, take, cand;
  logic [IDX_W-1:0] beat_idx, idx_q, idx_d;
  logic             err_q, err_d;

  logic                     s1_valid_q, s1_sop_q, s1_eop_q;
  logic signed [DATA_W-1:0] s1_re_q, s1_im_q;
  logic [IDX_W-1:0]         s1_idx_q;

  logic              s2_valid_q, s2_sop_q, s2_eop_q;
  logic [IDX_W-1:0]  s2_idx_q;
  logic [PW-1:0]     s2_pow_q;

  logic              have_q;
  logic [PW-1:0]     max_q;
  logic [IDX_W-1:0]  bin_q;

  logic              pv_q, perr_q;
  logic [IDX_W-1:0]  pbin_q;
  logic [PW-1:0]     ppow_q;

  logic signed [PW-1:0] re_x, im_x, re_sq, im_sq;
  logic [PW-1:0]        pow;

  assign src.source_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign acc      = src.source_valid && src.source_ready;
  // Outside a frame only an sop beat enters the pipeline; everything else is dropped.
  assign take     = acc && (src.source_sop || (state_q == COLLECT));
  assign beat_idx = src.source_sop ? '0 : idx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (take) begin
      idx_d = (beat_idx == LAST_IDX) ? '0 : beat_idx + IDX_W'(1);
      err_d = (src.source_sop ? 1'b0 : err_q) | (|src.source_error) |
              (src.source_eop && (beat_idx != LAST_IDX));
    end
    case (state_q)
      IDLE:    if (take) state_d = src.source_eop ? FLUSH : COLLECT;
      COLLECT: if (take && src.source_eop) state_d = FLUSH;
      FLUSH:   if (s2_valid_q && s2_eop_q) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Sign-extend before squaring so the product keeps all PW bits.
  assign re_x  = PW'(s1_re_q);
  assign im_x  = PW'(s1_im_q);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign pow   = unsigned'(re_sq) + unsigned'(im_sq);

`ifdef PEAK_SKIP_DC_EN
  assign cand = (s2_idx_q != '0);
`else
  assign cand = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_pow_q   <= '0;
      have_q     <= 1'b0;
      max_q      <= '0;
      bin_q      <= '0;
    end else begin
      s1_valid_q <= take;
      s1_sop_q   <= src.source_sop;
      s1_eop_q   <= src.source_eop;
      s1_re_q    <= src.source_real;
      s1_im_q    <= src.source_imag;
      s1_idx_q   <= beat_idx;
      s2_valid_q <= s1_valid_q;
      s2_sop_q   <= s1_sop_q;
      s2_eop_q   <= s1_eop_q;
      s2_idx_q   <= s1_idx_q;
      s2_pow_q   <= pow;
      if (s2_valid_q) begin
        // An sop restarts the search; strict > keeps the lowest bin on ties.
        if (s2_sop_q) begin
          have_q <= cand;
          max_q  <= cand ? s2_pow_q : '0;
          bin_q  <= s2_idx_q;
        end else if (cand && (!have_q || (s2_pow_q > max_q))) begin
          have_q <= 1'b1;
          max_q  <= s2_pow_q;
          bin_q  <= s2_idx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= 1'b0;
      pbin_q <= '0;
      ppow_q <= '0;
      perr_q <= 1'b0;
    end else begin
      pv_q <= (state_q == REPORT);
      if (state_q == REPORT) begin
        pbin_q <= bin_q;
        ppow_q <= max_q;
        perr_q <= err_q;
      end
    end
  end

  assign src.peak_valid = pv_q;
  assign src.peak_bin   = pbin_q;
  assign src.peak_power = ppow_q;
  assign src.frame_err  = perr_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: a behavioural model pushes expected reports with their
// due cycle, and a negedge monitor pops and compares them.
module tb_fft_peak_detect;
  localparam int DATA_W  = 14;
  localparam int FFT_LEN = 1024;
  localparam int IDX_W   = 10;
  localparam int PW      = 2 * DATA_W;
  localparam int EW      = 32 + 1 + IDX_W + PW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic [EW-1:0] exp_q[$];
  logic [IDX_W-1:0] lp_bin;
  logic [PW-1:0]    lp_pow;
  logic             lp_err;

  int   fr_re[FFT_LEN];
  int   fr_im[FFT_LEN];
  logic [1:0] fr_err[FFT_LEN];

  bit     m_active = 0, m_have = 0, m_err = 0;
  int     m_idx = 0, m_bin = 0;
  longint m_max = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_detect_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  fft_peak_detect #(.DATA_W(DATA_W), .FFT_LEN(FFT_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src         (bus),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_beat(input bit sop, input bit eop, input logic [1:0] err,
                            input int re, input int im, input int c);
    longint p;
    bit cnd;
    if (sop) begin
      m_active = 1; m_idx = 0; m_have = 0; m_max = 0; m_bin = 0; m_err = 0;
    end
    if (!m_active) return;
    p = longint'(re) * re + longint'(im) * im;
`ifdef PEAK_SKIP_DC_EN
    cnd = (m_idx != 0);
`else
    cnd = 1'b1;
`endif
    if (cnd && (!m_have || p > m_max)) begin
      m_have = 1; m_max = p; m_bin = m_idx;
    end
    if (err != 2'b00) m_err = 1;
    if (eop) begin
      if (m_idx != FFT_LEN - 1) m_err = 1;
      exp_q.push_back({32'(c + 4), m_err, IDX_W'(m_bin), PW'(m_max)});
      m_active = 0;
    end
    m_idx = (m_idx + 1) % FFT_LEN;
  endtask

  always @(negedge clk) begin
    logic [31:0] e_cyc;
    logic        e_err;
    logic [IDX_W-1:0] e_bin;
    logic [PW-1:0]    e_pow;
    if (rst_n && bus.peak_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_peak_valid", 64'd1, 64'd0);
      end else begin
        {e_cyc, e_err, e_bin, e_pow} = exp_q.pop_front();
        check("peak_cycle", 64'(cyc), 64'(e_cyc));
        check("peak_bin", 64'(bus.peak_bin), 64'(e_bin));
        check("peak_power", 64'(bus.peak_power), 64'(e_pow));
        check("frame_err", 64'(bus.frame_err), 64'(e_err));
        lp_bin = bus.peak_bin;
        lp_pow = bus.peak_power;
        lp_err = bus.frame_err;
      end
    end
  end

  task automatic send_beat(input bit sop, input bit eop, input logic [1:0] err,
                           input int re, input int im);
    bit acc;
    int c, guard;
    bus.source_valid = 1'b1;
    bus.source_sop   = sop;
    bus.source_eop   = eop;
    bus.source_error = err;
    bus.source_real  = DATA_W'(re);
    bus.source_imag  = DATA_W'(im);
    acc = 0; guard = 0; c = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = (bus.source_ready === 1'b1);
      c = cyc;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    bus.source_eop   = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    else model_beat(sop, eop, err, re, im, c);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < FFT_LEN; i++) begin
      fr_re[i] = 0; fr_im[i] = 0; fr_err[i] = 2'b00;
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(i == 0, i == n - 1, fr_err[i], fr_re[i], fr_im[i]);
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.source_valid = 1'b0;
    bus.source_sop   = 1'b0;
    bus.source_eop   = 1'b0;
    bus.source_error = 2'b00;
    bus.source_real  = '0;
    bus.source_imag  = '0;
    lp_bin = '0; lp_pow = '0; lp_err = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_peak_valid", 64'(bus.peak_valid), 64'd0);
    check("rst_peak_bin", 64'(bus.peak_bin), 64'd0);
    check("rst_peak_power", 64'(bus.peak_power), 64'd0);
    check("rst_frame_err", 64'(bus.frame_err), 64'd0);
    check("rst_source_ready", 64'(bus.source_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single tone at bin 37.
    clear_frame();
    fr_re[37] = 100; fr_im[37] = -50;
    send_frame(FFT_LEN, 0);
    wait_done();
    check("tone_bin", 64'(lp_bin), 64'd37);
    check("tone_power", 64'(lp_pow), 64'd12500);
    check("tone_err", 64'(lp_err), 64'd0);
    repeat (5) @(negedge clk);
    check("hold_bin", 64'(bus.peak_bin), 64'd37);
    check("hold_power", 64'(bus.peak_power), 64'd12500);
    check("hold_valid_low", 64'(bus.peak_valid), 64'd0);
    @(posedge clk);
    #1;

    // Equal full-scale peaks: lowest bin wins; valid gaps inserted.
    clear_frame();
    fr_re[5] = -8192; fr_im[5] = -8192;
    fr_re[900] = -8192; fr_im[900] = -8192;
    send_frame(FFT_LEN, 1);
    wait_done();
    check("tie_bin", 64'(lp_bin), 64'd5);
    check("tie_power", 64'(lp_pow), 64'd134217728);

    // Short frame: eop at index 511, ready drops through FLUSH/REPORT.
    @(posedge clk);
    #1;
    clear_frame();
    fr_re[200] = 3; fr_im[200] = 4;
    send_frame(512, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("short_ready_c%0d", k), 64'(bus.source_ready), (k == 4) ? 64'd1 : 64'd0);
    end
    wait_done();
    check("short_err", 64'(lp_err), 64'd1);

    // Error flag on bin 10, then a clean frame.
    @(posedge clk);
    #1;
    clear_frame();
    fr_err[10] = 2'b01;
    fr_re[600] = 7;
    send_frame(FFT_LEN, 0);
    wait_done();
    check("errflag_err", 64'(lp_err), 64'd1);
    @(posedge clk);
    #1;
    fr_err[10] = 2'b00;
    send_frame(FFT_LEN, 0);
    wait_done();
    check("clean_err", 64'(lp_err), 64'd0);

    // Reset mid-frame at bin 300, then stray beats, then a fresh frame.
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) send_beat(i == 0, 1'b0, 2'b00, (i == 150) ? 4000 : 0, 0);
    rst_n = 1'b0;
    m_active = 0;
    repeat (2) @(negedge clk);
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_ready", 64'(bus.source_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) send_beat(1'b0, (i == 19), 2'b00, 5000, 0);
    clear_frame();
    fr_re[400] = 20;
    send_frame(FFT_LEN, 0);
    wait_done();
    check("postrst_bin", 64'(lp_bin), 64'd400);
    check("postrst_power", 64'(lp_pow), 64'd400);

    // sop inside a frame restarts it, dropping the old peak and error.
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++)
      send_beat(i == 0, 1'b0, (i == 20) ? 2'b10 : 2'b00, (i == 50) ? 3000 : 0, 0);
    clear_frame();
    fr_re[700] = 9; fr_im[700] = 9;
    send_frame(FFT_LEN, 0);
    wait_done();
    check("restart_bin", 64'(lp_bin), 64'd700);
    check("restart_err", 64'(lp_err), 64'd0);

    // One-bin frame (sop and eop together).
    @(posedge clk);
    #1;
    send_beat(1'b1, 1'b1, 2'b00, 30, 40);
    wait_done();
    check("onebin_err", 64'(lp_err), 64'd1);

    // DC bin against a small bin 3.
    @(posedge clk);
    #1;
    clear_frame();
    fr_re[0] = 1000;
    fr_re[3] = 1; fr_im[3] = 1;
    send_frame(FFT_LEN, 0);
    wait_done();
`ifdef PEAK_SKIP_DC_EN
    check("dc_bin", 64'(lp_bin), 64'd3);
    check("dc_power", 64'(lp_pow), 64'd2);
`else
    check("dc_bin", 64'(lp_bin), 64'd0);
    check("dc_power", 64'(lp_pow), 64'd1000000);
`endif

    repeat (10) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 Parameter DATA_W, default 14, width of signed real/imag input samples.
REQ-002 Parameter FFT_LEN, default 1024, bins per frame (power of two); IDX_W = log2(FFT_LEN).
REQ-003 Port clk  in  1  single clock; all logic on the rising edge.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port source_valid  in  1  FFT output beat valid.
REQ-006 Port source_sop  in  1  first bin of a frame.
REQ-007 Port source_eop  in  1  last bin of a frame.
REQ-008 Port source_error  in  2  FFT core error code; nonzero marks the frame bad.
REQ-009 Port source_real  in  DATA_W  signed real part of the bin.
REQ-010 Port source_imag  in  DATA_W  signed imaginary part of the bin.
REQ-011 Port source_ready  out  1  stage accepts beats.
REQ-012 Port peak_valid  out  1  one-cycle pulse: result fields are valid.
REQ-013 Port peak_bin  out  IDX_W  bin index of maximum power.
REQ-014 Port peak_power  out  2*DATA_W  maximum re^2+im^2, unsigned.
REQ-015 Port frame_err  out  1  qualifies peak_valid: frame was malformed or flagged.

Function
REQ-016 A beat SHALL be accepted only when source_valid and source_ready are both 1.
REQ-017 FSM states SHALL be IDLE, COLLECT, FLUSH and REPORT.
REQ-018 source_ready SHALL be 1 in IDLE and COLLECT and 0 in FLUSH and REPORT.
REQ-019 In IDLE, accepted beats without source_sop SHALL be discarded.
REQ-020 An accepted sop beat SHALL clear the bin index to 0, clear the running max and error flag, and enter COLLECT.
REQ-021 The bin index SHALL increment per accepted beat and wrap modulo FFT_LEN.
REQ-022 Pipeline: stage 1 registers re/im/index/eop; stage 2 registers re*re+im*im (signed multiply, unsigned 2*DATA_W result, no overflow: max 2^(2*DATA_W-1)); stage 3 compares.
REQ-023 Compare SHALL use strict greater-than, so equal powers keep the lowest bin.
REQ-024 An accepted eop beat SHALL move the FSM to FLUSH; FLUSH SHALL last until stage 3 has processed the eop beat.
REQ-025 The FSM SHALL then enter REPORT for exactly one cycle, then return to IDLE.
REQ-026 For an eop beat accepted in cycle N, peak_valid SHALL be 1 in cycle N+4 only, with registered peak_bin, peak_power and frame_err.
REQ-027 frame_err SHALL be 1 if any beat in the frame had nonzero source_error, or if the eop beat index was not FFT_LEN-1.
REQ-028 An sop in COLLECT SHALL restart the frame at that beat (index 0, max cleared) without a report, and SHALL latch frame_err for the new frame.
REQ-029 A beat with both sop and eop SHALL start and end a one-bin frame (index 0, frame_err=1 unless FFT_LEN=1).
REQ-030 Outputs peak_bin, peak_power and frame_err SHALL hold their values between reports.

Reset
REQ-031 With rst_n low: FSM=IDLE, pipeline valids=0, peak_valid=0, peak_bin=0, peak_power=0, frame_err=0, source_ready=1.
REQ-032 Assertion mid-frame SHALL abort the frame with no report; the first sop after release starts a fresh frame.

Configuration
REQ-033 With PEAK_SKIP_DC_EN defined, bin 0 SHALL be excluded from the peak search (a frame with all other bins 0 reports bin 1, power 0); without it, bin 0 competes normally.

Verification
REQ-034 1024-bin frame, bin 37 = (100,-50), all other bins 0 -> peak_valid pulse 4 cycles after eop, peak_bin=37, peak_power=12500, frame_err=0.
REQ-035 Bins 5 and 900 both = (-8192,-8192) -> peak_bin=5, peak_power=134217728.
REQ-036 eop at index 511 -> peak_valid with frame_err=1; source_ready low through FLUSH/REPORT, then 1.
REQ-037 source_error=2'b01 on bin 10 -> frame_err=1; next clean frame -> frame_err=0.
REQ-038 rst_n pulsed low at bin 300 -> no peak_valid; beats before the next sop are ignored.
REQ-039 PEAK_SKIP_DC_EN defined, bin 0 = (1000,0), bin 3 = (1,1) -> peak_bin=3, peak_power=2; without the macro -> peak_bin=0, peak_power=1000000.
